// File: rtl/stack_cmd_driver.sv
`default_nettype none
// stack_cmd_driver: turns clear/push/pop/peek requests into single commands for a flagless LIFO stack.
// Build option STKDRV_OVERWRITE_EN: a push at full is legal (stack wraps, occupancy holds at DEPTH).
module stack_cmd_driver #(
  parameter int DEPTH     = 5,
  parameter int DATA_W    = 4,
  parameter int IDX_W     = 3,
  parameter int RDATA_LAT = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [1:0]        REQ_OP,
  input  logic [IDX_W-1:0]  REQ_INDEX,
  input  logic [DATA_W-1:0] REQ_DATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic              RSP_ERR,
  output logic              STK_RESET,
  output logic [1:0]        STK_COMMAND,
  output logic [IDX_W-1:0]  STK_INDEX,
  output logic [DATA_W-1:0] STK_WDATA,
  input  logic [DATA_W-1:0] STK_RDATA
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int LAT_W = (RDATA_LAT > 1) ? $clog2(RDATA_LAT) : 1;
  localparam int CMP_W = (IDX_W > CNT_W) ? IDX_W : CNT_W;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_PUSH  = 2'b01;
  localparam logic [1:0] OP_POP   = 2'b10;
  localparam logic [1:0] OP_PEEK  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RDATA_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        op_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  count;
  logic [LAT_W-1:0]  lat_cnt;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;
  logic              illegal;
  logic              lat_done;
  logic              issue_clear;
  logic              full;
  logic              empty;
  logic              peek_oob;

  assign full     = (count == CNT_MAX);
  assign empty    = (count == '0);
  assign peek_oob = (CMP_W'(REQ_INDEX) >= CMP_W'(count));
  assign lat_done = (lat_cnt == LAT_LAST);

  // Legality is judged against the occupancy seen at the accept edge.
  always_comb begin
    illegal = 1'b0;
    case (REQ_OP)
      OP_PUSH: begin
`ifdef STKDRV_OVERWRITE_EN
        illegal = 1'b0;
`else
        illegal = full;
`endif
      end
      OP_POP:  illegal = empty;
      OP_PEEK: illegal = peek_oob;
      default: illegal = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    REQ_READY   = 1'b0;
    RSP_VALID   = 1'b0;
    STK_COMMAND = 2'b00;
    STK_INDEX   = '0;
    STK_WDATA   = '0;
    issue_clear = 1'b0;
    case (state)
      S_IDLE: begin
        REQ_READY = RESET;
        if (REQ_VALID) begin
          state_nxt = illegal ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        case (op_q)
          OP_CLEAR: begin
            issue_clear = 1'b1;
            state_nxt   = S_RESP;
          end
          OP_PUSH: begin
            STK_COMMAND = OP_PUSH;
            STK_WDATA   = data_q;
            state_nxt   = S_RESP;
          end
          OP_POP: begin
            STK_COMMAND = OP_POP;
            state_nxt   = S_WAIT;
          end
          default: begin
            STK_COMMAND = OP_PEEK;
            STK_INDEX   = idx_q;
            state_nxt   = S_WAIT;
          end
        endcase
      end
      S_WAIT: begin
        if (lat_done) begin
          state_nxt = S_RESP;
        end
      end
      default: begin
        RSP_VALID = 1'b1;
        if (RSP_READY) begin
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  // The stack is cleared along with the driver and on an issued clear.
  assign STK_RESET = ~RESET | issue_clear;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_ERR   = rsp_err_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      op_q       <= OP_CLEAR;
      idx_q      <= '0;
      data_q     <= '0;
      count      <= '0;
      lat_cnt    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (REQ_VALID) begin
            op_q       <= REQ_OP;
            idx_q      <= REQ_INDEX;
            data_q     <= REQ_DATA;
            rsp_data_q <= '0;
            rsp_err_q  <= illegal;
          end
        end
        S_ISSUE: begin
          lat_cnt <= '0;
          case (op_q)
            OP_CLEAR: count <= '0;
            OP_PUSH: begin
              if (!full) begin
                count <= count + 1'b1;
              end
            end
            OP_POP:  count <= count - 1'b1;
            default: count <= count;
          endcase
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (lat_done) begin
            rsp_data_q <= STK_RDATA;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stack_cmd_driver.sv
`default_nettype none
// tb_stack_cmd_driver: directed scoreboard bench with a behavioural 5-entry circular LIFO behind the driver.
module tb_stack_cmd_driver;

  localparam int DEPTH = 5;
  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_PUSH  = 2'b01;
  localparam logic [1:0] OP_POP   = 2'b10;
  localparam logic [1:0] OP_PEEK  = 2'b11;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic [1:0] REQ_OP = 2'b00;
  logic [2:0] REQ_INDEX = 3'd0;
  logic [3:0] REQ_DATA = 4'd0;
  logic       RSP_VALID;
  logic       RSP_READY = 1'b1;
  logic [3:0] RSP_DATA;
  logic       RSP_ERR;
  logic       STK_RESET;
  logic [1:0] STK_COMMAND;
  logic [2:0] STK_INDEX;
  logic [3:0] STK_WDATA;
  logic [3:0] STK_RDATA = 4'd0;

  int n_cmp = 0;
  int n_bad = 0;
  int cmd_cnt = 0;
  int clr_cnt = 0;
  logic [4:0] exp_q[$];

  always #5 CLK = ~CLK;

  stack_cmd_driver #(.DEPTH(DEPTH), .DATA_W(4), .IDX_W(3), .RDATA_LAT(1)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
    .REQ_INDEX(REQ_INDEX), .REQ_DATA(REQ_DATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .STK_RESET(STK_RESET), .STK_COMMAND(STK_COMMAND), .STK_INDEX(STK_INDEX),
    .STK_WDATA(STK_WDATA), .STK_RDATA(STK_RDATA)
  );

  // Circular LIFO: registered read data, valid the cycle after the command edge.
  logic [3:0] mem [DEPTH];
  int sp = 0;
  always @(posedge CLK) begin
    if (STK_RESET) begin
      sp <= 0;
      STK_RDATA <= 4'd0;
    end else begin
      case (STK_COMMAND)
        2'b01: begin
          mem[sp] <= STK_WDATA;
          sp <= (sp + 1) % DEPTH;
        end
        2'b10: begin
          STK_RDATA <= mem[(sp + DEPTH - 1) % DEPTH];
          sp <= (sp + DEPTH - 1) % DEPTH;
        end
        2'b11: STK_RDATA <= mem[(sp + 2 * DEPTH - 1 - int'(STK_INDEX)) % DEPTH];
        default: ;
      endcase
    end
  end

  always @(negedge CLK) begin
    if (RESET) begin
      if (STK_COMMAND != 2'b00) cmd_cnt++;
      if (STK_RESET) clr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic [1:0] op, input logic [2:0] idx,
                        input logic [3:0] d, input logic ee, input logic [3:0] ed,
                        input int lat, input int ncmd, input int nclr, input int hold);
    int c0;
    int r0;
    int cyc;
    logic [4:0] exp;
    cyc = 0;
    while (!REQ_READY && cyc < 20) begin
      @(negedge CLK);
      cyc++;
    end
    check($sformatf("%s/req_ready", tag), REQ_READY, 1);
    c0 = cmd_cnt;
    r0 = clr_cnt;
    REQ_VALID = 1'b1;
    REQ_OP = op;
    REQ_INDEX = idx;
    REQ_DATA = d;
    RSP_READY = (hold == 0);
    exp_q.push_back({ee, ed});
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    REQ_OP = 2'b00;
    REQ_INDEX = 3'd0;
    REQ_DATA = 4'd0;
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (!RSP_VALID && cyc < 20);
    check($sformatf("%s/latency", tag), cyc, lat);
    exp = exp_q.pop_front();
    check($sformatf("%s/rsp_data", tag), RSP_DATA, exp[3:0]);
    check($sformatf("%s/rsp_err", tag), RSP_ERR, exp[4]);
    repeat (hold) begin
      @(negedge CLK);
      check($sformatf("%s/hold_valid", tag), RSP_VALID, 1);
      check($sformatf("%s/hold_data", tag), RSP_DATA, exp[3:0]);
      check($sformatf("%s/hold_err", tag), RSP_ERR, exp[4]);
      check($sformatf("%s/hold_req_ready", tag), REQ_READY, 0);
    end
    RSP_READY = 1'b1;
    @(posedge CLK);
    #1;
    check($sformatf("%s/rsp_done", tag), RSP_VALID, 0);
    check($sformatf("%s/stk_cmds", tag), cmd_cnt - c0, ncmd);
    check($sformatf("%s/stk_clears", tag), clr_cnt - r0, nclr);
  endtask

  initial begin
    int c0;
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    repeat (3) @(negedge CLK);
    check("rst/req_ready", REQ_READY, 0);
    check("rst/rsp_valid", RSP_VALID, 0);
    check("rst/rsp_data", RSP_DATA, 0);
    check("rst/rsp_err", RSP_ERR, 0);
    check("rst/stk_cmd", STK_COMMAND, 0);
    check("rst/stk_index", STK_INDEX, 0);
    check("rst/stk_wdata", STK_WDATA, 0);
    check("rst/stk_reset", STK_RESET, 1);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    check("rel/req_ready", REQ_READY, 1);
    check("rel/stk_reset", STK_RESET, 0);

    do_req("push3", OP_PUSH, 0, 4'd3, 0, 4'd0, 2, 1, 0, 0);
    do_req("push7", OP_PUSH, 0, 4'd7, 0, 4'd0, 2, 1, 0, 0);
    do_req("push9", OP_PUSH, 0, 4'd9, 0, 4'd0, 2, 1, 0, 0);
    do_req("pop9", OP_POP, 0, 4'd0, 0, 4'd9, 3, 1, 0, 0);
    do_req("pop7", OP_POP, 0, 4'd0, 0, 4'd7, 3, 1, 0, 0);
    do_req("pop3", OP_POP, 0, 4'd0, 0, 4'd3, 3, 1, 0, 0);
    do_req("underflow", OP_POP, 0, 4'd0, 1, 4'd0, 1, 0, 0, 0);

    for (int i = 1; i <= 5; i++) do_req("fill", OP_PUSH, 0, 4'(i), 0, 4'd0, 2, 1, 0, 0);
`ifdef STKDRV_OVERWRITE_EN
    do_req("push_full", OP_PUSH, 0, 4'd6, 0, 4'd0, 2, 1, 0, 0);
    do_req("pop_wrap", OP_POP, 0, 4'd0, 0, 4'd6, 3, 1, 0, 0);
    for (int i = 5; i >= 2; i--) do_req("drain", OP_POP, 0, 4'd0, 0, 4'(i), 3, 1, 0, 0);
`else
    do_req("overflow", OP_PUSH, 0, 4'd6, 1, 4'd0, 1, 0, 0, 0);
    for (int i = 5; i >= 1; i--) do_req("drain", OP_POP, 0, 4'd0, 0, 4'(i), 3, 1, 0, 0);
`endif
    do_req("drained", OP_POP, 0, 4'd0, 1, 4'd0, 1, 0, 0, 0);

    do_req("push2", OP_PUSH, 0, 4'd2, 0, 4'd0, 2, 1, 0, 0);
    do_req("push4", OP_PUSH, 0, 4'd4, 0, 4'd0, 2, 1, 0, 0);
    do_req("push8", OP_PUSH, 0, 4'd8, 0, 4'd0, 2, 1, 0, 0);
    do_req("peek0", OP_PEEK, 0, 4'd0, 0, 4'd8, 3, 1, 0, 0);
    do_req("peek1", OP_PEEK, 1, 4'd0, 0, 4'd4, 3, 1, 0, 0);
    do_req("peek2", OP_PEEK, 2, 4'd0, 0, 4'd2, 3, 1, 0, 0);
    do_req("peek3", OP_PEEK, 3, 4'd0, 1, 4'd0, 1, 0, 0, 0);
    do_req("peek7", OP_PEEK, 7, 4'd0, 1, 4'd0, 1, 0, 0, 0);
    do_req("pop8_hold", OP_POP, 0, 4'd0, 0, 4'd8, 3, 1, 0, 4);
    do_req("pop4", OP_POP, 0, 4'd0, 0, 4'd4, 3, 1, 0, 0);
    do_req("pop2", OP_POP, 0, 4'd0, 0, 4'd2, 3, 1, 0, 0);
    do_req("peek_empty", OP_PEEK, 0, 4'd0, 1, 4'd0, 1, 0, 0, 0);

    // Reset while a pop sits in WAIT: the response is abandoned.
    do_req("push5", OP_PUSH, 0, 4'd5, 0, 4'd0, 2, 1, 0, 0);
    REQ_VALID = 1'b1;
    REQ_OP = OP_POP;
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    REQ_OP = 2'b00;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    #1;
    check("abort/req_ready", REQ_READY, 0);
    check("abort/rsp_valid", RSP_VALID, 0);
    check("abort/rsp_data", RSP_DATA, 0);
    check("abort/rsp_err", RSP_ERR, 0);
    check("abort/stk_cmd", STK_COMMAND, 0);
    check("abort/stk_reset", STK_RESET, 1);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    c0 = cmd_cnt;
    repeat (3) @(negedge CLK);
    check("abort/no_cmd", cmd_cnt - c0, 0);
    check("abort/no_rsp", RSP_VALID, 0);
    do_req("abort/pop", OP_POP, 0, 4'd0, 1, 4'd0, 1, 0, 0, 0);

    do_req("pushA", OP_PUSH, 0, 4'd10, 0, 4'd0, 2, 1, 0, 0);
    do_req("pushB", OP_PUSH, 0, 4'd11, 0, 4'd0, 2, 1, 0, 0);
    do_req("clear", OP_CLEAR, 0, 4'd0, 0, 4'd0, 2, 0, 1, 0);
    do_req("clear/pop", OP_POP, 0, 4'd0, 1, 4'd0, 1, 0, 0, 0);
    do_req("push_after_clr", OP_PUSH, 0, 4'd12, 0, 4'd0, 2, 1, 0, 0);
    do_req("pop_after_clr", OP_POP, 0, 4'd0, 0, 4'd12, 3, 1, 0, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
